// File: rtl/memory_read_req_tracker.sv
// Read-request tracker: allocates request IDs and serials, issues {id, addr} reads, and returns responses by serial.
// Optional watchdog (per-ID age counters driving errTimeout) is enabled by RSD_MEM_READ_TRACKER_WATCHDOG_EN.
module memory_read_req_tracker #(
    parameter int ID_WIDTH       = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 64,
    parameter int SERIAL_WIDTH   = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    reqValid,
    input  logic [ADDR_WIDTH-1:0]   reqAddr,
    output logic                    reqReady,
    output logic [SERIAL_WIDTH-1:0] reqSerial,
    output logic                    arValid,
    output logic [ID_WIDTH-1:0]     arId,
    output logic [ADDR_WIDTH-1:0]   arAddr,
    input  logic                    arReady,
    input  logic                    rValid,
    input  logic [ID_WIDTH-1:0]     rId,
    input  logic [DATA_WIDTH-1:0]   rData,
    output logic                    rReady,
    output logic                    respValid,
    output logic [SERIAL_WIDTH-1:0] respSerial,
    output logic [DATA_WIDTH-1:0]   respData,
    input  logic                    respReady,
    output logic                    errUnknownId,
    output logic                    errTimeout
);
    localparam int unsigned NUM_IDS = 1 << ID_WIDTH;

    logic [NUM_IDS-1:0]      busy;
    logic [SERIAL_WIDTH-1:0] serialOf [NUM_IDS];
    logic [SERIAL_WIDTH-1:0] nextSerial;
    logic                    anyFree;
    logic [ID_WIDTH-1:0]     allocId;
    logic                    accept;
    logic                    rFire;
    logic                    rHit;

    // Scan downwards so the last assignment wins: lowest free index of the registered busy vector.
    always_comb begin
        anyFree = 1'b0;
        allocId = '0;
        for (int unsigned i = NUM_IDS; i > 0; i--) begin
            if (!busy[i-1]) begin
                anyFree = 1'b1;
                allocId = ID_WIDTH'(i - 1);
            end
        end
    end

    always_comb begin
        reqReady  = anyFree && (!arValid || arReady);
        reqSerial = nextSerial;
        accept    = reqValid && reqReady;
        rReady    = !respValid || respReady;
        rFire     = rValid && rReady;
        rHit      = rFire && busy[rId];
    end

    // allocId is never busy and rId must be busy for a hit, so set and clear never target the same bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy         <= '0;
            nextSerial   <= '0;
            arValid      <= 1'b0;
            arId         <= '0;
            arAddr       <= '0;
            respValid    <= 1'b0;
            respSerial   <= '0;
            respData     <= '0;
            errUnknownId <= 1'b0;
        end else begin
            if (accept) begin
                busy[allocId] <= 1'b1;
                arValid       <= 1'b1;
                arId          <= allocId;
                arAddr        <= reqAddr;
                nextSerial    <= nextSerial + 1'b1;
            end else if (arValid && arReady) begin
                arValid <= 1'b0;
            end

            if (rHit) begin
                busy[rId]  <= 1'b0;
                respValid  <= 1'b1;
                respSerial <= serialOf[rId];
                respData   <= rData;
            end else if (respValid && respReady) begin
                respValid <= 1'b0;
            end

            if (rFire && !busy[rId]) begin
                errUnknownId <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            serialOf[allocId] <= nextSerial;
        end
    end

`ifdef RSD_MEM_READ_TRACKER_WATCHDOG_EN
    logic [7:0] age [NUM_IDS];
    logic       anyExpired;
    logic       timeoutFlag;

    // Counters saturate so a long-stuck ID cannot wrap back below the limit.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUM_IDS; i++) begin
            if (accept && (allocId == ID_WIDTH'(i))) begin
                age[i] <= '0;
            end else if (busy[i] && (age[i] != '1)) begin
                age[i] <= age[i] + 8'd1;
            end
        end
    end

    always_comb begin
        anyExpired = 1'b0;
        for (int unsigned i = 0; i < NUM_IDS; i++) begin
            if (busy[i] && (age[i] == 8'(TIMEOUT_CYCLES))) begin
                anyExpired = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timeoutFlag <= 1'b0;
        end else if (anyExpired) begin
            timeoutFlag <= 1'b1;
        end
    end

    assign errTimeout = timeoutFlag;
`else
    assign errTimeout = 1'b0;
`endif

endmodule

// File: tb/tb_memory_read_req_tracker.sv
// Directed self-checking bench for memory_read_req_tracker: allocation, fill, ordering, backpressure, errors, wrap, reset.
module tb_memory_read_req_tracker;
    logic        clk = 1'b0;
    logic        rst;
    logic        reqValid;
    logic [31:0] reqAddr;
    logic        reqReady;
    logic [7:0]  reqSerial;
    logic        arValid;
    logic [3:0]  arId;
    logic [31:0] arAddr;
    logic        arReady;
    logic        rValid;
    logic [3:0]  rId;
    logic [63:0] rData;
    logic        rReady;
    logic        respValid;
    logic [7:0]  respSerial;
    logic [63:0] respData;
    logic        respReady;
    logic        errUnknownId;
    logic        errTimeout;

    int checks   = 0;
    int failures = 0;

    memory_read_req_tracker #(
        .ID_WIDTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(64), .SERIAL_WIDTH(8), .TIMEOUT_CYCLES(255)
    ) dut (
        .clk(clk), .rst(rst),
        .reqValid(reqValid), .reqAddr(reqAddr), .reqReady(reqReady), .reqSerial(reqSerial),
        .arValid(arValid), .arId(arId), .arAddr(arAddr), .arReady(arReady),
        .rValid(rValid), .rId(rId), .rData(rData), .rReady(rReady),
        .respValid(respValid), .respSerial(respSerial), .respData(respData), .respReady(respReady),
        .errUnknownId(errUnknownId), .errTimeout(errTimeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1; reqValid = 1'b0; reqAddr = '0; arReady = 1'b1;
        rValid = 1'b0; rId = '0; rData = '0; respReady = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        doReset();
        #1;
        checks++; if (reqReady !== 1'b1) begin failures++; $display("FAIL reset_reqReady got=%0b exp=1", reqReady); end
        checks++; if (arValid !== 1'b0 || arId !== 4'd0 || arAddr !== 32'd0) begin failures++; $display("FAIL reset_ar got=%0b/%0d/%h exp=0/0/0", arValid, arId, arAddr); end
        checks++; if (respValid !== 1'b0 || respSerial !== 8'd0 || respData !== 64'd0) begin failures++; $display("FAIL reset_resp got=%0b/%0d/%h exp=0/0/0", respValid, respSerial, respData); end
        checks++; if (errUnknownId !== 1'b0 || errTimeout !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b/%0b exp=0/0", errUnknownId, errTimeout); end
        checks++; if (reqSerial !== 8'd0 || rReady !== 1'b1) begin failures++; $display("FAIL reset_serial_rready got=%0d/%0b exp=0/1", reqSerial, rReady); end
    endtask

    task automatic test_single_read();
        doReset();
        reqValid = 1'b1; reqAddr = 32'h1000;
        #1;
        checks++; if (reqReady !== 1'b1 || reqSerial !== 8'd0) begin failures++; $display("FAIL single_accept got=%0b/%0d exp=1/0", reqReady, reqSerial); end
        tick();
        reqValid = 1'b0;
        checks++; if (arValid !== 1'b1 || arId !== 4'd0 || arAddr !== 32'h1000) begin failures++; $display("FAIL single_ar got=%0b/%0d/%h exp=1/0/1000", arValid, arId, arAddr); end
        tick();
        checks++; if (arValid !== 1'b0) begin failures++; $display("FAIL single_ar_clear got=%0b exp=0", arValid); end
        rValid = 1'b1; rId = 4'd0; rData = 64'hDEAD_BEEF;
        tick();
        rValid = 1'b0;
        checks++; if (respValid !== 1'b1 || respSerial !== 8'd0 || respData !== 64'hDEAD_BEEF) begin failures++; $display("FAIL single_resp got=%0b/%0d/%h exp=1/0/deadbeef", respValid, respSerial, respData); end
        tick();
        checks++; if (respValid !== 1'b0) begin failures++; $display("FAIL single_resp_clear got=%0b exp=0", respValid); end
        reqValid = 1'b1; reqAddr = 32'h2000;
        tick();
        reqValid = 1'b0;
        checks++; if (arId !== 4'd0 || arValid !== 1'b1) begin failures++; $display("FAIL single_id_freed got=%0d exp=0", arId); end
        checks++; if (errUnknownId !== 1'b0) begin failures++; $display("FAIL single_no_err got=%0b exp=0", errUnknownId); end
    endtask

    task automatic test_fill();
        doReset();
        reqValid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            reqAddr = 32'h100 * i;
            #1;
            checks++; if (reqReady !== 1'b1 || reqSerial !== 8'(i)) begin failures++; $display("FAIL fill_accept i=%0d got=%0b/%0d exp=1/%0d", i, reqReady, reqSerial, i); end
            tick();
            checks++; if (arValid !== 1'b1 || arId !== 4'(i) || arAddr !== 32'h100 * i) begin failures++; $display("FAIL fill_ar i=%0d got=%0b/%0d/%h exp=1/%0d", i, arValid, arId, arAddr, i); end
        end
        reqAddr = 32'h1700;
        #1;
        checks++; if (reqReady !== 1'b0) begin failures++; $display("FAIL fill_full got=%0b exp=0", reqReady); end
        tick();
        checks++; if (arValid !== 1'b0 || reqReady !== 1'b0) begin failures++; $display("FAIL fill_held got=%0b/%0b exp=0/0", arValid, reqReady); end
        rValid = 1'b1; rId = 4'd5; rData = 64'h55;
        #1;
        checks++; if (reqReady !== 1'b0 || rReady !== 1'b1) begin failures++; $display("FAIL fill_free_same_cycle got=%0b/%0b exp=0/1", reqReady, rReady); end
        tick();
        rValid = 1'b0;
        checks++; if (respValid !== 1'b1 || respSerial !== 8'd5 || respData !== 64'h55) begin failures++; $display("FAIL fill_resp got=%0b/%0d/%h exp=1/5/55", respValid, respSerial, respData); end
        #1;
        checks++; if (reqReady !== 1'b1 || reqSerial !== 8'd16) begin failures++; $display("FAIL fill_after_free got=%0b/%0d exp=1/16", reqReady, reqSerial); end
        tick();
        reqValid = 1'b0;
        checks++; if (arValid !== 1'b1 || arId !== 4'd5 || arAddr !== 32'h1700) begin failures++; $display("FAIL fill_realloc got=%0b/%0d/%h exp=1/5/1700", arValid, arId, arAddr); end
    endtask

    task automatic test_out_of_order();
        logic [3:0] order [3];
        order[0] = 4'd2; order[1] = 4'd0; order[2] = 4'd1;
        doReset();
        reqValid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            reqAddr = 32'hA000 + i;
            tick();
            checks++; if (arId !== 4'(i)) begin failures++; $display("FAIL ooo_issue i=%0d got=%0d exp=%0d", i, arId, i); end
        end
        reqValid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rValid = 1'b1; rId = order[i]; rData = 64'hA0 + 64'(order[i]);
            tick();
            checks++; if (respValid !== 1'b1 || respSerial !== 8'(order[i]) || respData !== 64'hA0 + 64'(order[i])) begin
                failures++; $display("FAIL ooo_resp i=%0d got=%0b/%0d/%h exp=1/%0d", i, respValid, respSerial, respData, order[i]);
            end
        end
        rValid = 1'b0;
        tick();
        checks++; if (respValid !== 1'b0) begin failures++; $display("FAIL ooo_drain got=%0b exp=0", respValid); end
    endtask

    task automatic test_backpressure();
        doReset();
        arReady = 1'b0;
        reqValid = 1'b1; reqAddr = 32'hCAFE_0000;
        tick();
        reqAddr = 32'hBEEF_0000;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (arValid !== 1'b1 || arId !== 4'd0 || arAddr !== 32'hCAFE_0000 || reqReady !== 1'b0) begin
                failures++; $display("FAIL bp_ar_stall i=%0d got=%0b/%0d/%h/%0b exp=1/0/cafe0000/0", i, arValid, arId, arAddr, reqReady);
            end
            tick();
        end
        arReady = 1'b1;
        #1;
        checks++; if (reqReady !== 1'b1 || reqSerial !== 8'd1) begin failures++; $display("FAIL bp_release got=%0b/%0d exp=1/1", reqReady, reqSerial); end
        tick();
        reqValid = 1'b0;
        checks++; if (arValid !== 1'b1 || arId !== 4'd1 || arAddr !== 32'hBEEF_0000) begin failures++; $display("FAIL bp_reload got=%0b/%0d/%h exp=1/1/beef0000", arValid, arId, arAddr); end
        respReady = 1'b0;
        rValid = 1'b1; rId = 4'd0; rData = 64'h1111;
        tick();
        rId = 4'd1; rData = 64'h2222;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (respValid !== 1'b1 || respData !== 64'h1111 || respSerial !== 8'd0 || rReady !== 1'b0) begin
                failures++; $display("FAIL bp_resp_stall i=%0d got=%0b/%h/%0d/%0b exp=1/1111/0/0", i, respValid, respData, respSerial, rReady);
            end
            tick();
        end
        respReady = 1'b1;
        #1;
        checks++; if (rReady !== 1'b1) begin failures++; $display("FAIL bp_rready got=%0b exp=1", rReady); end
        tick();
        rValid = 1'b0;
        checks++; if (respValid !== 1'b1 || respData !== 64'h2222 || respSerial !== 8'd1) begin failures++; $display("FAIL bp_resp_next got=%0b/%h/%0d exp=1/2222/1", respValid, respData, respSerial); end
    endtask

    task automatic test_unknown_id();
        doReset();
        rValid = 1'b1; rId = 4'd7; rData = 64'h7777;
        #1;
        checks++; if (errUnknownId !== 1'b0 || rReady !== 1'b1) begin failures++; $display("FAIL unk_before got=%0b/%0b exp=0/1", errUnknownId, rReady); end
        tick();
        rValid = 1'b0;
        checks++; if (respValid !== 1'b0 || errUnknownId !== 1'b1) begin failures++; $display("FAIL unk_flag got=%0b/%0b exp=0/1", respValid, errUnknownId); end
        repeat (3) tick();
        checks++; if (errUnknownId !== 1'b1) begin failures++; $display("FAIL unk_sticky got=%0b exp=1", errUnknownId); end
        doReset();
        checks++; if (errUnknownId !== 1'b0) begin failures++; $display("FAIL unk_cleared got=%0b exp=0", errUnknownId); end
    endtask

    task automatic test_serial_wrap_and_reset();
        doReset();
        for (int i = 0; i < 257; i++) begin
            reqValid = 1'b1; reqAddr = 32'(i);
            #1;
            checks++; if (reqReady !== 1'b1 || reqSerial !== 8'(i)) begin failures++; $display("FAIL wrap_serial i=%0d got=%0b/%0d exp=1/%0d", i, reqReady, reqSerial, i % 256); end
            tick();
            reqValid = 1'b0;
            rValid = 1'b1; rId = arId; rData = 64'(i);
            tick();
            rValid = 1'b0;
            checks++; if (respSerial !== 8'(i) || rId !== 4'd0) begin failures++; $display("FAIL wrap_resp i=%0d got=%0d/%0d exp=%0d/0", i, respSerial, rId, i % 256); end
        end
        tick();
        reqValid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            reqAddr = 32'hF000 + i;
            tick();
        end
        reqValid = 1'b0; arReady = 1'b0; respReady = 1'b0;
        rValid = 1'b1; rId = 4'd0; rData = 64'h77;
        tick();
        rValid = 1'b0;
        checks++; if (arValid !== 1'b1 || arId !== 4'd2 || respValid !== 1'b1 || respSerial !== 8'd1) begin
            failures++; $display("FAIL prereset_state got=%0b/%0d/%0b/%0d exp=1/2/1/1", arValid, arId, respValid, respSerial);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0; arReady = 1'b1; respReady = 1'b1;
        checks++; if (arValid !== 1'b0 || arId !== 4'd0 || arAddr !== 32'd0 || respValid !== 1'b0 || respSerial !== 8'd0 || respData !== 64'd0) begin
            failures++; $display("FAIL midreset_outputs got=%0b/%0d/%h/%0b/%0d/%h exp=all zero", arValid, arId, arAddr, respValid, respSerial, respData);
        end
        checks++; if (reqReady !== 1'b1 || reqSerial !== 8'd0 || errUnknownId !== 1'b0) begin failures++; $display("FAIL midreset_req got=%0b/%0d/%0b exp=1/0/0", reqReady, reqSerial, errUnknownId); end
        rValid = 1'b1; rId = 4'd2; rData = 64'h99;
        tick();
        rValid = 1'b0;
        checks++; if (errUnknownId !== 1'b1 || respValid !== 1'b0) begin failures++; $display("FAIL stale_id got=%0b/%0b exp=1/0", errUnknownId, respValid); end
        reqValid = 1'b1; reqAddr = 32'h4242;
        #1;
        checks++; if (reqSerial !== 8'd0) begin failures++; $display("FAIL postreset_serial got=%0d exp=0", reqSerial); end
        tick();
        reqValid = 1'b0;
        checks++; if (arValid !== 1'b1 || arId !== 4'd0 || arAddr !== 32'h4242) begin failures++; $display("FAIL postreset_id got=%0b/%0d/%h exp=1/0/4242", arValid, arId, arAddr); end
    endtask

    task automatic test_timeout();
        doReset();
        reqValid = 1'b1; reqAddr = 32'h5000;
        tick();
        reqValid = 1'b0;
        repeat (255) tick();
        checks++; if (errTimeout !== 1'b0) begin failures++; $display("FAIL timeout_early got=%0b exp=0", errTimeout); end
        tick();
`ifdef RSD_MEM_READ_TRACKER_WATCHDOG_EN
        checks++; if (errTimeout !== 1'b1) begin failures++; $display("FAIL timeout_set got=%0b exp=1", errTimeout); end
`else
        checks++; if (errTimeout !== 1'b0) begin failures++; $display("FAIL timeout_tied got=%0b exp=0", errTimeout); end
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        test_reset();
        test_single_read();
        test_fill();
        test_out_of_order();
        test_backpressure();
        test_unknown_id();
        test_serial_wrap_and_reset();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
